// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared constants and FSM state type for the PS/2 key decoder
package ps2_key_decoder_pkg;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [7:0] ASCII_NONE = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_PROC = 2'd2
   } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// rtl/ps2_scan2ascii.sv - scan-code set 2 to lowercase ASCII ROM (digits and letters only)
module ps2_scan2ascii
   import ps2_key_decoder_pkg::*;
(
   input  logic [7:0] code,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = ASCII_NONE;
      case (code)
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h1C: ascii = 8'h61;
         8'h32: ascii = 8'h62;
         8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;
         8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;
         8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;
         8'h42: ascii = 8'h6B;
         8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;
         8'h31: ascii = 8'h6E;
         8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;
         8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;
         8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;
         8'h1D: ascii = 8'h77;
         8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;
         8'h1A: ascii = 8'h7A;
         default: ascii = ASCII_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - pops PS/2 scan bytes, tracks one held key, drives six hex digits
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int CNT_W           = 8,
   parameter bit BLANK_WHEN_IDLE = 1'b1
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   output logic             kb_nextdata_n,
   output logic [7:0]       key_code,
   output logic [7:0]       key_ascii,
   output logic             key_ext,
   output logic             key_held,
   output logic [CNT_W-1:0] press_count,
   output logic [7:0]       seg0,
   output logic [7:0]       seg1,
   output logic [7:0]       seg2,
   output logic [7:0]       seg3,
   output logic [7:0]       seg4,
   output logic [7:0]       seg5
);

   function automatic logic [7:0] hex2seg(input logic [3:0] h);
      logic [7:0] s;
      case (h)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   state_t     state, state_nxt;
   logic [7:0] byte_r;
   logic       brk, ext;
   logic       latch, apply;
   logic [7:0] rom_ascii;
   logic       is_break, is_ext, hit;
   logic       show;
   logic [7:0] cnt_disp;

   ps2_scan2ascii u_scan2ascii (
      .code  (byte_r),
      .ascii (rom_ascii)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // The pop strobe is decoded from state so an async reset releases it at once.
   always_comb begin
      state_nxt     = state;
      kb_nextdata_n = 1'b1;
      latch         = 1'b0;
      apply         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (kb_ready) begin
               latch     = 1'b1;
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            kb_nextdata_n = 1'b0;
            state_nxt     = ST_PROC;
         end
         ST_PROC: begin
            apply     = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    byte_r <= 8'h00;
      else if (latch) byte_r <= kb_data;
   end

   assign is_break = (byte_r == PS2_BREAK);
   assign is_ext   = (byte_r == PS2_EXT);
   assign hit      = key_held && (byte_r == key_code);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         brk         <= 1'b0;
         ext         <= 1'b0;
         key_code    <= 8'h00;
         key_ascii   <= 8'h00;
         key_ext     <= 1'b0;
         key_held    <= 1'b0;
         press_count <= '0;
      end else if (apply) begin
         if (is_break) begin
            brk <= 1'b1;
         end else if (is_ext) begin
            ext <= 1'b1;
         end else if (brk) begin
            // Release matches on code alone; a mismatched break is dropped.
            if (hit) begin
               key_held  <= 1'b0;
               key_code  <= 8'h00;
               key_ascii <= 8'h00;
               key_ext   <= 1'b0;
            end
            brk <= 1'b0;
            ext <= 1'b0;
         end else if (hit && (ext == key_ext)) begin
            ext <= 1'b0;
         end else begin
            key_code    <= byte_r;
            key_ext     <= ext;
            key_held    <= 1'b1;
            key_ascii   <= ext ? ASCII_NONE : rom_ascii;
            press_count <= press_count + 1'b1;
            ext         <= 1'b0;
         end
      end
   end

   assign show     = key_held || !BLANK_WHEN_IDLE;
   assign cnt_disp = 8'(press_count);

   assign seg0 = show ? hex2seg(key_code[3:0])  : SEG_BLANK;
   assign seg1 = show ? hex2seg(key_code[7:4])  : SEG_BLANK;
   assign seg2 = show ? hex2seg(key_ascii[3:0]) : SEG_BLANK;
   assign seg3 = show ? hex2seg(key_ascii[7:4]) : SEG_BLANK;
   assign seg4 = hex2seg(cnt_disp[3:0]);
   assign seg5 = hex2seg(cnt_disp[7:4]);

endmodule
